// File: rtl/if_prefetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : if_prefetch_unit
// Brief    : Instruction fetch stage with a credit-limited prefetch queue.
// Revision : 1.0
// ============================================================================
module if_prefetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_inst,
  output logic        id_valid,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  input  logic        id_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt
);

  localparam int          c_AW    = $clog2(DEPTH);
  localparam int          c_CW    = c_AW + 1;
  localparam logic [31:0] c_NOP   = 32'h0000_0013;
  localparam logic [c_CW-1:0] c_FULL    = c_CW'(DEPTH);
  localparam logic [c_CW:0]   c_DEPTH_W = (c_CW + 1)'(DEPTH);

  logic [31:0]     r_fetch_pc;
  logic [31:0]     r_resp_pc;
  logic [c_AW-1:0] r_rd;
  logic [c_AW-1:0] r_wr;
  logic [c_CW-1:0] r_count;
  logic [c_CW-1:0] r_outstanding;
  logic [c_CW-1:0] r_drop;
  logic [31:0]     r_q_inst [DEPTH];
  logic [31:0]     r_q_pc   [DEPTH];

  logic [c_CW:0]   w_inflight;
  logic [c_CW-1:0] w_out_after_resp;
  logic [31:0]     w_redir_pc;
  logic            w_fire;
  logic            w_drop_resp;
  logic            w_push;
  logic            w_pop;

  assign w_inflight       = {1'b0, r_count} + {1'b0, r_outstanding};
  assign w_out_after_resp = r_outstanding - c_CW'(imem_resp_valid);
  assign w_redir_pc       = redirect_pc & ~32'h0000_0003;

  // Credit check counts queued plus in-flight words so a push can never overflow.
  assign imem_req_valid = reset && !redirect_valid && !halt && (w_inflight < c_DEPTH_W);
  assign imem_req_addr  = r_fetch_pc;

  assign w_fire      = imem_req_valid && imem_req_ready;
  assign w_drop_resp = imem_resp_valid && (r_drop != '0);
  assign w_push      = imem_resp_valid && (r_drop == '0) && !redirect_valid;
  assign w_pop       = id_valid && id_ready;

  assign id_valid = (r_count != '0);
  assign id_inst  = id_valid ? r_q_inst[r_rd] : c_NOP;
  assign id_pc    = id_valid ? r_q_pc[r_rd]   : 32'h0000_0000;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fetch_pc    <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_rd          <= '0;
      r_wr          <= '0;
      r_count       <= '0;
      r_outstanding <= '0;
      r_drop        <= '0;
    end else if (redirect_valid) begin
      // Every word still in flight after this cycle belongs to the old path.
      r_fetch_pc    <= w_redir_pc;
      r_resp_pc     <= w_redir_pc;
      r_rd          <= r_wr;
      r_count       <= '0;
      r_outstanding <= w_out_after_resp;
      r_drop        <= w_out_after_resp;
    end else begin
      if (w_fire) begin
        r_fetch_pc <= r_fetch_pc + 32'd4;
      end
      r_outstanding <= w_out_after_resp + c_CW'(w_fire);
      if (w_drop_resp) begin
        r_drop <= r_drop - 1'b1;
      end
      if (w_push) begin
        r_wr      <= r_wr + 1'b1;
        r_resp_pc <= r_resp_pc + 32'd4;
      end
      if (w_pop) begin
        r_rd <= r_rd + 1'b1;
      end
      r_count <= r_count + c_CW'(w_push) - c_CW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_inst[r_wr] <= imem_resp_inst;
      r_q_pc[r_wr]   <= r_resp_pc;
    end
  end

  a_no_overflow : assert property (@(posedge clk) disable iff (!reset)
    w_push |-> (r_count != c_FULL))
    else $error("prefetch queue overflow");

endmodule
`default_nettype wire

// File: doc/if_prefetch_unit.md
# if_prefetch_unit

Instruction-fetch stage for the 5-stage pipelined CPU. It owns the fetch PC, issues in-order requests to an instruction memory with variable latency, buffers returned instructions in a small prefetch queue, and presents one instruction plus its PC per cycle to the IF/ID pipeline register. It supports backpressure from the decode stage (stall), redirect on taken branches or jumps (flush), and a halt that stops fetching after an ecall.

## Interface
- DEPTH, 4, prefetch queue entries; power of two, ≥2; also the maximum of queued plus in-flight instructions.
- RESET_PC, 32'h0000_0000, fetch PC loaded at reset.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- imem_req_valid  out  1  request for the instruction at imem_req_addr.
- imem_req_addr  out  32  byte address of the request, always 4-aligned.
- imem_req_ready  in  1  memory accepts the request this cycle.
- imem_resp_valid  in  1  one instruction returned this cycle; responses are in request order, at least 1 cycle after acceptance.
- imem_resp_inst  in  32  returned instruction word.
- id_valid  out  1  queue head is valid.
- id_inst  out  32  queue head instruction; 32'h0000_0013 (NOP) when the queue is empty.
- id_pc  out  32  PC of the queue head; 0 when the queue is empty.
- id_ready  in  1  decode consumes the head this cycle (stall = 0).
- redirect_valid  in  1  flush and restart fetch at redirect_pc.
- redirect_pc  in  32  new fetch PC; bits [1:0] are ignored and treated as 0.
- halt  in  1  level-sensitive; stop issuing requests.

## Operation
- State: fetch_pc (32), queue of DEPTH {inst, pc}, rd/wr pointers, occupancy count (log2(DEPTH)+1 bits), outstanding count (same width), drop count (same width).
- Request: imem_req_valid = !redirect_valid && !halt && (occupancy + outstanding < DEPTH). On acceptance (valid && ready): fetch_pc += 4 (wraps modulo 2^32) and outstanding += 1.
- Response: outstanding -= 1. If drop > 0, drop -= 1 and the word is discarded. Otherwise {imem_resp_inst, pc} is written at wr; pc comes from an internal response-PC tracker, which is a copy of fetch_pc advanced per accepted response.
- Pop: when id_valid && id_ready, rd advances. Push and pop can happen in the same cycle, and occupancy is then unchanged. There is no bypass: a response becomes visible on id_* one cycle later.
- The credit rule guarantees no overflow. Any push when full is a design error and is flagged by an assertion.
- Redirect (has priority over everything):
  - Queue is emptied (occupancy 0, rd = wr).
  - fetch_pc and the response-PC tracker are set to redirect_pc.
  - Any response arriving in the same cycle is discarded.
  - drop is set to outstanding after that cycle's response decrement.
  - No request is issued in the redirect cycle.
  - A pop in the redirect cycle is still honoured by decode but has no effect on state.
- Halt: only request issue stops. In-flight responses are still accepted, and the queue keeps draining to decode. A redirect during halt updates fetch_pc; fetch resumes from there when halt deasserts.

## Timing
- Reset asserted (asynchronous):
  - fetch_pc = RESET_PC.
  - All counters and pointers are 0.
  - imem_req_valid = 0, id_valid = 0, id_inst = NOP, id_pc = 0.
- First rising edge after reset release: imem_req_valid = 1 with imem_req_addr = RESET_PC, provided halt = 0.
- Minimum latency from request acceptance to id_valid is 2 cycles: 1 for memory, 1 for the queue.
- Sustained throughput is 1 instruction/cycle when memory latency is ≤ DEPTH−1 and id_ready = 1.
- imem_req_addr equals fetch_pc at all times. It is held stable while valid && !ready unless a redirect occurs.
- id_* outputs come directly from registers and queue storage; there is no combinational path from imem_resp_* to id_*.
- Reset mid-operation: all in-flight state is abandoned immediately. Responses to pre-reset requests are not expected after reset; the memory is reset by the same signal.

## Test plan
- Reset and stream:
  - Stimulus: release reset; memory with 1-cycle latency, always ready; id_ready = 1.
  - Required: requests 0x0, 0x4, 0x8, … on consecutive cycles; id_pc 0x0 is valid on cycle 2 with the matching inst; then one new PC per cycle.
- Backpressure fill:
  - Stimulus: id_ready = 0 for 10 cycles with DEPTH = 4.
  - Required: exactly 4 requests are accepted and the queue reaches full; imem_req_valid = 0 until the first pop, and issue resumes 1 cycle after it.
- Redirect with in-flight requests:
  - Stimulus: memory latency 3; assert redirect_valid with redirect_pc = 0x100 while 2 requests are outstanding.
  - Required: the 2 old responses are dropped; id_valid = 0 until the instruction at 0x100 arrives; the next PCs are 0x100, 0x104.
- Redirect in the same cycle as a response:
  - Stimulus: response arrives in the redirect cycle.
  - Required: that response is discarded and drop = outstanding − 1.
- Halt:
  - Stimulus: assert halt while 1 request is in flight and 2 entries are queued.
  - Required: no new requests; the 3 instructions are delivered in order; id_valid = 0 afterwards.
- Asynchronous reset mid-stream:
  - Stimulus: drive reset to 0 between clock edges while the queue is non-empty.
  - Required: id_valid and imem_req_valid go to 0 without waiting for a clock edge; after release, fetch restarts at RESET_PC.
